rv_data_lsu: RTL and testbench

RV_DATA_LSU -- requirements
Module: rv_data_lsu

---
 rtl/rv_data_lsu.sv | 230 +++++++++++++++++++++++
 tb/tb_rv_data_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_data_lsu.sv
// rv_data_lsu: single-outstanding load/store unit over a local word memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        zero-extend byte/half loads
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           right-aligned load data (0 for stores and faults)
//   rsp_err             access fault (out of range, illegal size, trapped misalign)
//   busy                high whenever a request is in flight
module rv_data_lsu #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic enter;
  logic accept;

  logic [31:0] mem [DEPTH];

  logic              c_we;
  logic [1:0]        c_size;
  logic              c_uns;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;

  logic              o_we;
  logic [1:0]        o_size;
  logic              o_uns;
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       o_wdata;

  logic [1:0]  lo;
  logic        oob;
  logic        bad;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] rword;
  logic [31:0] sh;
  logic [31:0] ld;
  logic        mem_wr;

  assign accept    = req_valid && (state == S_IDLE);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enter     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_nxt = '0;
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
            enter     = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == LAST) begin
          state_nxt = S_RESP;
          enter     = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_we    <= 1'b0;
      c_size  <= 2'b00;
      c_uns   <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else if (accept) begin
      c_we    <= req_we;
      c_size  <= req_size;
      c_uns   <= req_unsigned;
      c_addr  <= req_addr;
      c_wdata <= req_wdata;
    end
  end

  // With LATENCY=1 the access happens on the acceptance edge itself,
  // so the live request feeds the memory while still in IDLE.
  assign o_we    = (state == S_IDLE) ? req_we       : c_we;
  assign o_size  = (state == S_IDLE) ? req_size     : c_size;
  assign o_uns   = (state == S_IDLE) ? req_unsigned : c_uns;
  assign o_addr  = (state == S_IDLE) ? req_addr     : c_addr;
  assign o_wdata = (state == S_IDLE) ? req_wdata    : c_wdata;

  assign oob = (o_addr >> 2) >= DEPTH_W;
  assign idx = o_addr[AW+1:2];

  always_comb begin
    lo = o_addr[1:0];
    unique case (o_size)
      2'b01:   lo = {o_addr[1], 1'b0};
      2'b10:   lo = 2'b00;
      default: lo = o_addr[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis = ((o_size == 2'b01) && o_addr[0]) ||
               ((o_size == 2'b10) && (o_addr[1:0] != 2'b00));
  assign bad = oob || (o_size == 2'b11) || mis;
`else
  assign bad = oob || (o_size == 2'b11);
`endif

  always_comb begin
    be    = 4'b0000;
    wlane = o_wdata;
    unique case (o_size)
      2'b00: begin
        be    = 4'b0001 << lo;
        wlane = {4{o_wdata[7:0]}};
      end
      2'b01: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wlane = {2{o_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = o_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = o_wdata;
      end
    endcase
  end

  assign rword = mem[idx];
  assign sh    = rword >> {lo, 3'b000};

  always_comb begin
    ld = 32'h0;
    unique case (o_size)
      2'b00: ld = o_uns ? {24'h0, sh[7:0]}
                        : {{24{sh[7]}}, sh[7:0]};
      2'b01: ld = o_uns ? {16'h0, sh[15:0]}
                        : {{16{sh[15]}}, sh[15:0]};
      2'b10: ld = rword;
      default: ld = 32'h0;
    endcase
  end

  // Gating with rst keeps a store from landing while reset is held.
  assign mem_wr = enter && o_we && !bad && !rst;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (enter) begin
      rsp_err   <= bad;
      rsp_rdata <= (bad || o_we) ? 32'h0 : ld;
    end
  end

endmodule

// File: tb/tb_rv_data_lsu.sv
// tb_rv_data_lsu: randomized self-checking bench for rv_data_lsu.
// Drives a LATENCY=1 and a LATENCY=4 instance against a byte-level model.
module tb_rv_data_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_we = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic v1 = 1'b0, v4 = 1'b0;
  logic rr1 = 1'b0, rr4 = 1'b0;
  logic rdy1, rdy4, rv1, rv4, er1, er4, bz1, bz4;
  logic [31:0] rd1, rd4;

  logic [31:0] m1 [1024];
  logic [31:0] m4 [1024];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv_data_lsu #(.DEPTH(1024), .ADDR_W(32), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_rdata(rd1), .rsp_err(er1), .busy(bz1)
  );

  rv_data_lsu #(.DEPTH(1024), .ADDR_W(32), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst),
    .req_valid(v4), .req_ready(rdy4),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv4), .rsp_ready(rr4),
    .rsp_rdata(rd4), .rsp_err(er4), .busy(bz4)
  );

  task automatic model_op(input bit d4, input logic we,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
    int unsigned idx, off, nb;
    logic [31:0] w, mask, v;
    idx = a / 4;
    er = (sz == 2'd3) || (idx >= 1024);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) er = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) er = 1'b1;
`endif
    rd = 32'h0;
    if (er) return;
    nb = 1 << sz;
    off = a % 4;
    if (sz == 2'd1) off = off - (off % 2);
    if (sz == 2'd2) off = 0;
    w = d4 ? m4[idx] : m1[idx];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (we) begin
      w = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      if (d4) m4[idx] = w;
      else m1[idx] = w;
    end else begin
      v = (w >> (8 * off)) & mask;
      if (nb < 4 && !uns && v[8*nb-1]) v = v | ~mask;
      rd = v;
    end
  endtask

  // One full transaction; ok drops on timeout, unstable held outputs,
  // req_ready/busy wrong while in flight, or not idle after handshake.
  task automatic txn(input bit d4, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input int stall,
                     output logic [31:0] rd, output logic er,
                     output int lat, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    rr1 = 1'b0; rr4 = 1'b0;
    if (d4) v4 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (!(d4 ? rdy4 : rdy1) && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) ok = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b0; v4 = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if ((d4 ? rdy4 : rdy1) || !(d4 ? bz4 : bz1)) ok = 1'b0;
    end while (!(d4 ? rv4 : rv1) && lat < 50);
    if (lat >= 50) ok = 1'b0;
    rd = d4 ? rd4 : rd1;
    er = d4 ? er4 : er1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!(d4 ? rv4 : rv1) || (d4 ? rdy4 : rdy1)) ok = 1'b0;
      if ((d4 ? rd4 : rd1) !== rd || (d4 ? er4 : er1) !== er) ok = 1'b0;
      req_addr = $urandom; req_wdata = $urandom;
    end
    if (d4) rr4 = 1'b1; else rr1 = 1'b1;
    @(posedge clk); #1;
    rr1 = 1'b0; rr4 = 1'b0;
    @(negedge clk);
    if (!(d4 ? rdy4 : rdy1) || (d4 ? bz4 : bz1) || (d4 ? rv4 : rv1))
      ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if ({rv1, er1, bz1} !== 3'b000 || rd1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_u1 got v/e/b=%b%b%b rd=%h want 000 0", rv1, er1, bz1, rd1); end
    n_chk++; if ({rv4, er4, bz4} !== 3'b000 || rd4 !== 32'h0) begin
      n_fail++; $display("FAIL reset_u4 got v/e/b=%b%b%b rd=%h want 000 0", rv4, er4, bz4, rd4); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b%b want 11", rdy1, rdy4); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    model_op(0, 1, 2'd2, 0, 32'h1E0, 32'd130, erd, eer);
    txn(0, 1, 2'd2, 0, 32'h1E0, 32'd130, 0, rd, er, lat, ok);
    n_chk++; if (lat !== 1 || ok !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL basic_sw got lat=%0d ok=%b err=%b rd=%h want 1 1 0 0", lat, ok, er, rd); end
    model_op(0, 0, 2'd2, 0, 32'h1E0, 32'h0, erd, eer);
    txn(0, 0, 2'd2, 0, 32'h1E0, 32'h0, 0, rd, er, lat, ok);
    n_chk++; if (lat !== 1 || ok !== 1'b1 || er !== 1'b0 || rd !== 32'd130) begin
      n_fail++; $display("FAIL basic_lw got lat=%0d ok=%b err=%b rd=%h want 1 1 0 82", lat, ok, er, rd); end
  endtask

  task automatic test_bytes();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    logic [31:0] want [4];
    logic [1:0] sz [4];
    logic us [4];
    logic [31:0] ad [4];
    want = '{32'h0000AB82, 32'hFFFFFFAB, 32'h000000AB, 32'hFFFFAB82};
    sz = '{2'd2, 2'd0, 2'd0, 2'd1};
    us = '{1'b0, 1'b0, 1'b1, 1'b0};
    ad = '{32'h1E0, 32'h1E1, 32'h1E1, 32'h1E0};
    model_op(0, 1, 2'd0, 0, 32'h1E1, 32'h55AB, erd, eer);
    txn(0, 1, 2'd0, 0, 32'h1E1, 32'h55AB, 0, rd, er, lat, ok);
    n_chk++; if (er !== 1'b0 || ok !== 1'b1) begin
      n_fail++; $display("FAIL sb got err=%b ok=%b want 0 1", er, ok); end
    for (int i = 0; i < 4; i++) begin
      model_op(0, 0, sz[i], us[i], ad[i], 32'h0, erd, eer);
      txn(0, 0, sz[i], us[i], ad[i], 32'h0, 0, rd, er, lat, ok);
      n_chk++; if (rd !== want[i] || rd !== erd || er !== 1'b0) begin
        n_fail++; $display("FAIL byte_ld%0d got rd=%h err=%b want %h 0", i, rd, er, want[i]); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    model_op(0, 1, 2'd2, 0, 32'h1000, 32'hDEADBEEF, erd, eer);
    txn(0, 1, 2'd2, 0, 32'h1000, 32'hDEADBEEF, 0, rd, er, lat, ok);
    n_chk++; if (er !== 1'b1 || rd !== 32'h0 || ok !== 1'b1) begin
      n_fail++; $display("FAIL oob_sw got err=%b rd=%h ok=%b want 1 0 1", er, rd, ok); end
    model_op(0, 0, 2'd3, 0, 32'h1E0, 32'h0, erd, eer);
    txn(0, 0, 2'd3, 0, 32'h1E0, 32'h0, 0, rd, er, lat, ok);
    n_chk++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL size11 got err=%b rd=%h want 1 0", er, rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    model_op(0, 0, 2'd2, 0, 32'h1E2, 32'h0, erd, eer);
    txn(0, 0, 2'd2, 0, 32'h1E2, 32'h0, 0, rd, er, lat, ok);
`ifdef LSU_MISALIGN_TRAP_EN
    n_chk++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL misalign got err=%b rd=%h want 1 0", er, rd); end
`else
    n_chk++; if (er !== 1'b0 || rd !== 32'h0000AB82) begin
      n_fail++; $display("FAIL misalign got err=%b rd=%h want 0 0000ab82", er, rd); end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    model_op(1, 1, 2'd2, 0, 32'h300, 32'h12345678, erd, eer);
    txn(1, 1, 2'd2, 0, 32'h300, 32'h12345678, 0, rd, er, lat, ok);
    n_chk++; if (lat !== 4 || ok !== 1'b1 || er !== 1'b0) begin
      n_fail++; $display("FAIL stall_sw got lat=%0d ok=%b err=%b want 4 1 0", lat, ok, er); end
    model_op(1, 0, 2'd2, 0, 32'h300, 32'h0, erd, eer);
    txn(1, 0, 2'd2, 0, 32'h300, 32'h0, 3, rd, er, lat, ok);
    n_chk++; if (lat !== 4 || ok !== 1'b1 || rd !== 32'h12345678) begin
      n_fail++; $display("FAIL stall_lw got lat=%0d ok=%b rd=%h want 4 1 12345678", lat, ok, rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'd55;
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({rv4, er4, bz4, rdy4} !== 4'b0001 || rd4 !== 32'h0) begin
      n_fail++; $display("FAIL abort_outs got v/e/b/r=%b%b%b%b rd=%h want 0001 0", rv4, er4, bz4, rdy4, rd4); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_op(1, 0, 2'd2, 0, 32'h200, 32'h0, erd, eer);
    txn(1, 0, 2'd2, 0, 32'h200, 32'h0, 0, rd, er, lat, ok);
    n_chk++; if (rd !== erd || er !== 1'b0 || ok !== 1'b1) begin
      n_fail++; $display("FAIL abort_mem got rd=%h err=%b ok=%b want %h 0 1", rd, er, ok, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, eer, we, us;
    logic [1:0] sz; int lat, st; bit ok, d4;
    for (int i = 0; i < 80; i++) begin
      d4 = 1'(i % 2);
      we = 1'($urandom);
      us = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 65535)
                                      : $urandom_range(0, 32'hFFF);
      wd = $urandom;
      st = $urandom_range(0, 2);
      model_op(d4, we, sz, us, a, wd, erd, eer);
      txn(d4, we, sz, us, a, wd, st, rd, er, lat, ok);
      n_chk++; if (rd !== erd || er !== eer || ok !== 1'b1 || lat !== (d4 ? 4 : 1)) begin
        n_fail++; $display("FAIL rand%0d got rd=%h err=%b ok=%b lat=%0d want %h %b 1 %0d", i, rd, er, ok, lat, erd, eer, d4 ? 4 : 1); end
    end
  endtask

  task automatic test_memory();
    int bad1, bad4;
    bad1 = 0; bad4 = 0;
    for (int i = 0; i < 1024; i++) begin
      if (u1.mem[i] !== m1[i]) bad1++;
      if (u4.mem[i] !== m4[i]) bad4++;
    end
    n_chk++; if (bad1 !== 0) begin
      n_fail++; $display("FAIL mem_u1 got %0d differing words want 0", bad1); end
    n_chk++; if (bad4 !== 0) begin
      n_fail++; $display("FAIL mem_u4 got %0d differing words want 0", bad4); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m1[i] = $urandom;
      m4[i] = $urandom;
      u1.mem[i] = m1[i];
      u4.mem[i] = m4[i];
    end
    test_reset();
    test_basic();
    test_bytes();
    test_errors();
    test_misalign();
    test_stall();
    test_reset_abort();
    test_random();
    test_memory();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule
